hex_display_ctrl: RTL and testbench

//  Drives NUM_DIGITS active-low 7-segment displays (DE1-SoC HEX0..HEX5) from one DATA_W-bit value.

---
 rtl/hex_display_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: shared-decoder 7-segment driver for NUM_DIGITS displays.
// Converts one digit per cycle into a shadow, commits atomically, optional blink.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 24,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DATA_W-1:0]       load_data,
    input  logic [1:0]              load_mode,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int NB = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(BLINK_DIV + 1);

    localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);

    localparam logic [1:0] MODE_HEX  = 2'd0;
    localparam logic [1:0] MODE_DASH = 2'd1;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    if (DATA_W < 1 || DATA_W > 4 * NUM_DIGITS) begin : g_bad_data_w
        $error("hex_display_ctrl: DATA_W must be in 1..4*NUM_DIGITS");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("hex_display_ctrl: BLINK_DIV must be >= 1");
    end

    logic [1:0]    state;
    logic [NB-1:0] data_q;
    logic [NB-1:0] data_ext;
    logic [1:0]    mode_q;
    logic          lz_q;
    logic [IW-1:0] idx;
    logic          zero_run;
    logic [SW-1:0] shadow;
    logic [SW-1:0] display;
    logic [SW-1:0] disp_d;
    logic [3:0]    nib;
    logic [6:0]    cur_seg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          phase;
    logic          phase_d;

    // Nibble to active-low segment pattern, bit0 = segment a
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign load_ready = (state == IDLE);

    // Zero-extend the request to a whole number of digits
    always_comb begin
        data_ext = '0;
        data_ext[DATA_W-1:0] = load_data;
    end

    // Pick the current nibble and its segment pattern for the active mode
    always_comb begin
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) nib = data_q[4*i +: 4];
        end
        case (mode_q)
            MODE_HEX: begin
                if (lz_q && zero_run && nib == 4'h0 && idx != '0)
                    cur_seg = SEG_BLANK;
                else
                    cur_seg = hex7(nib);
            end
            MODE_DASH: cur_seg = SEG_DASH;
            default:   cur_seg = SEG_BLANK;
        endcase
    end

    // Accept, convert MSB digit first into the shadow, then commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            mode_q   <= MODE_HEX;
            lz_q     <= 1'b0;
            idx      <= '0;
            zero_run <= 1'b1;
            shadow   <= '1;
            display  <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        data_q   <= data_ext;
                        mode_q   <= load_mode;
                        lz_q     <= lz_blank;
                        idx      <= IDX_TOP;
                        zero_run <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (idx == IW'(i)) shadow[7*i +: 7] <= cur_seg;
                    end
                    if (nib != 4'h0) zero_run <= 1'b0;
                    if (idx == '0)
                        state <= COMMIT;
                    else
                        idx <= idx - 1'b1;
                end
                COMMIT: begin
                    display <= shadow;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next blink counter/phase and next committed pattern
    always_comb begin
        cnt_d   = cnt;
        phase_d = phase;
        if (!blink_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt == CNT_TOP) begin
            cnt_d   = '0;
            phase_d = ~phase;
        end else begin
            cnt_d = cnt + 1'b1;
        end
        disp_d = (state == COMMIT) ? shadow : display;
    end

    // Blink prescaler, free-running with respect to the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            phase <= phase_d;
        end
    end

    // Registered segment output, in step with commit and blink phase
    always_ff @(posedge clk) begin
        if (rst)
            seg <= '1;
        else
            seg <= phase_d ? '1 : disp_d;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed vectors for hex_display_ctrl
// NUM_DIGITS=6, DATA_W=24, BLINK_DIV=4.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [23:0] load_data;
    logic [1:0]  load_mode;
    logic        lz_blank;
    logic        blink_en;
    logic [41:0] seg;

    int nvec = 0;
    int nerr = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;

    localparam logic [41:0] P_ABCD   = {S0, S0, SA, SB, SC, SD};
    localparam logic [41:0] P_ABCDLZ = {BL, BL, SA, SB, SC, SD};
    localparam logic [41:0] P_ZEROLZ = {BL, BL, BL, BL, BL, S0};
    localparam logic [41:0] P_102LZ  = {BL, BL, BL, S1, S0, S2};
    localparam logic [41:0] P_789EF0 = {S7, S8, S9, SE, SF, S0};
    localparam logic [41:0] P_123456 = {S1, S2, S3, S4, S5, S6};
    localparam logic [41:0] P_DASH   = {6{DS}};
    localparam logic [41:0] P_BLANK  = {6{BL}};

    hex_display_ctrl #(
        .NUM_DIGITS(6),
        .DATA_W    (24),
        .BLINK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_mode (load_mode),
        .lz_blank  (lz_blank),
        .blink_en  (blink_en),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for ready, accept, then count cycles until ready returns
    task automatic do_load(input logic [23:0] d, input logic [1:0] m,
                           input logic lz, output int busy);
        int n;
        load_data  = d;
        load_mode  = m;
        lz_blank   = lz;
        load_valid = 1'b1;
        n = 0;
        while (!load_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        busy = 0;
        while (!load_ready && busy < 50) begin
            tick();
            busy++;
        end
    endtask

    initial begin
        int busy;
        int n;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_mode  = 2'd0;
        lz_blank   = 1'b0;
        blink_en   = 1'b0;
        repeat (2) tick();
        chk("rst_seg", 64'(seg), 64'(P_BLANK));
        chk("rst_ready", 64'(load_ready), 64'd1);
        rst = 1'b0;
        tick();
        chk("idle_seg", 64'(seg), 64'(P_BLANK));

        // Basic HEX load and latency
        do_load(24'h00ABCD, 2'd0, 1'b0, busy);
        chk("hex_busy", 64'(busy), 64'd7);
        chk("hex_abcd", 64'(seg), 64'(P_ABCD));

        // Leading-zero blanking
        do_load(24'h00ABCD, 2'd0, 1'b1, busy);
        chk("lz_abcd", 64'(seg), 64'(P_ABCDLZ));
        do_load(24'h000000, 2'd0, 1'b1, busy);
        chk("lz_zero", 64'(seg), 64'(P_ZEROLZ));
        do_load(24'h000102, 2'd0, 1'b1, busy);
        chk("lz_inner0", 64'(seg), 64'(P_102LZ));
        do_load(24'h789EF0, 2'd0, 1'b1, busy);
        chk("lz_full", 64'(seg), 64'(P_789EF0));

        // Modes
        do_load(24'h123456, 2'd1, 1'b0, busy);
        chk("dash_busy", 64'(busy), 64'd7);
        chk("dash", 64'(seg), 64'(P_DASH));
        do_load(24'h123456, 2'd2, 1'b0, busy);
        chk("blank_busy", 64'(busy), 64'd7);
        chk("blank", 64'(seg), 64'(P_BLANK));
        do_load(24'h000000, 2'd1, 1'b0, busy);
        chk("dash2", 64'(seg), 64'(P_DASH));
        do_load(24'h123456, 2'd3, 1'b0, busy);
        chk("mode3", 64'(seg), 64'(P_BLANK));

        // Request during conversion is ignored
        load_data  = 24'h00ABCD;
        load_mode  = 2'd0;
        lz_blank   = 1'b0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        load_data  = 24'h123456;
        lz_blank   = 1'b1;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        n = 0;
        while (!load_ready && n < 50) begin
            tick();
            n++;
        end
        chk("pulse_ready", 64'(load_ready), 64'd1);
        chk("pulse_seg", 64'(seg), 64'(P_ABCD));
        repeat (3) tick();
        chk("noqueue_ready", 64'(load_ready), 64'd1);
        chk("noqueue_seg", 64'(seg), 64'(P_ABCD));

        // Held request is accepted once ready returns
        load_data  = 24'h000000;
        load_mode  = 2'd1;
        load_valid = 1'b1;
        tick();
        load_mode  = 2'd0;
        load_data  = 24'h123456;
        chk("hold_busy_ready", 64'(load_ready), 64'd0);
        do_load(24'h123456, 2'd0, 1'b0, busy);
        chk("hold_busy", 64'(busy), 64'd7);
        chk("hold_seg", 64'(seg), 64'(P_123456));

        // Blink
        do_load(24'h00ABCD, 2'd0, 1'b0, busy);
        chk("pre_blink", 64'(seg), 64'(P_ABCD));
        blink_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (((k / 4) % 2) == 1)
                chk("blink_hid", 64'(seg), 64'(P_BLANK));
            else
                chk("blink_vis", 64'(seg), 64'(P_ABCD));
        end
        blink_en = 1'b0;
        tick();
        chk("blink_off", 64'(seg), 64'(P_ABCD));

        // Reset in the middle of a conversion
        do_load(24'h123456, 2'd0, 1'b0, busy);
        chk("pre_rst", 64'(seg), 64'(P_123456));
        load_data  = 24'h00ABCD;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        chk("mid_conv_busy", 64'(load_ready), 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_seg", 64'(seg), 64'(P_BLANK));
        chk("mid_rst_ready", 64'(load_ready), 64'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_seg", 64'(seg), 64'(P_BLANK));
        do_load(24'h00ABCD, 2'd0, 1'b0, busy);
        chk("post_rst_busy", 64'(busy), 64'd7);
        chk("post_rst_abcd", 64'(seg), 64'(P_ABCD));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
